// File: rtl/usb_endpoint_arbiter_pkg.sv
// usb_endpoint_arbiter_pkg: shared defaults, FSM encoding and endpoint field position
package usb_endpoint_arbiter_pkg;

    localparam int         NUM_EP_DEF      = 4;
    localparam logic [7:0] ACK_TIMEOUT_DEF = 8'd200;
    localparam int         EP_FIELD_HI     = 7;
    localparam int         EP_FIELD_LO     = 6;

    typedef enum logic [2:0] {
        IDLE,
        RX_CAPTURE,
        RX_WAIT_ACK,
        RX_RELEASE,
        WR_ISSUE,
        WR_WAIT,
        WR_DONE
    } state_e;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/usb_endpoint_arbiter_rr_arbiter_4.sv
// rr_arbiter_4: combinational round-robin pick, searching from last+1 and wrapping to last
module rr_arbiter_4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    logic [1:0] idx;

    // Scan farthest-first so the nearest requester after last is the final assignment
    always_comb begin
        grant = last;
        idx   = '0;
        valid = |req;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) grant = idx;
        end
    end

endmodule

// File: rtl/usb_endpoint_arbiter.sv
// usb_endpoint_arbiter: shares one FT245 port between 4 endpoints; reads routed by byte[7:6],
// writes granted round-robin, both guarded by an ACK/complete timeout.
module usb_endpoint_arbiter
    import usb_endpoint_arbiter_pkg::*;
#(
    parameter int         NUM_EP      = NUM_EP_DEF,
    parameter logic [7:0] ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [NUM_EP-1:0]     EP_WR_REQ,
    input  logic [8*NUM_EP-1:0]   EP_WR_BYTE,
    output logic [NUM_EP-1:0]     EP_WR_DONE,
    output logic [NUM_EP-1:0]     EP_RX_VALID,
    output logic [7:0]            EP_RX_DATA,
    input  logic [NUM_EP-1:0]     EP_RX_ACK,
    output logic                  WRITE_EN,
    output logic [7:0]            WRITE_BYTE,
    input  logic                  WRITE_COMPLETE,
    input  logic                  DATA_BYTE_READY,
    input  logic [7:0]            USB_REGISTER_DECODE,
    input  logic                  FT_245_SM_BUSY,
    output logic                  RSB_INT_EN,
    output logic                  ENDPOINT_BUSY,
    output logic                  TIMEOUT_ERR
);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_q, last_d;
    logic [7:0] wr_byte_q, wr_byte_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       to_q, to_d;
    logic [1:0] arb_grant;
    logic       arb_valid;
    logic [1:0] target;

    rr_arbiter_4 u_rr (
        .req   (EP_WR_REQ),
        .last  (last_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign target = rx_data_q[EP_FIELD_HI:EP_FIELD_LO];

    always_comb begin
        state_d   = state_q;
        to_d      = 1'b0;
        grant_d   = grant_q;
        last_d    = last_q;
        wr_byte_d = wr_byte_q;
        rx_data_d = rx_data_q;
        case (state_q)
            IDLE: begin
                if (DATA_BYTE_READY) begin
                    state_d = RX_CAPTURE;
                end else if (!FT_245_SM_BUSY && arb_valid) begin
                    state_d   = WR_ISSUE;
                    grant_d   = arb_grant;
                    wr_byte_d = EP_WR_BYTE[{arb_grant, 3'b000} +: 8];
                end
            end
            RX_CAPTURE: begin
                rx_data_d = USB_REGISTER_DECODE;
                state_d   = RX_WAIT_ACK;
            end
            RX_WAIT_ACK: begin
                if (EP_RX_ACK[target]) begin
                    state_d = RX_RELEASE;
                end else if (cnt_q + 8'd1 == ACK_TIMEOUT) begin
                    state_d = RX_RELEASE;
                    to_d    = 1'b1;
                end
            end
            RX_RELEASE: state_d = IDLE;
            WR_ISSUE:   state_d = WR_WAIT;
            WR_WAIT: begin
                if (WRITE_COMPLETE) begin
                    state_d = WR_DONE;
                end else if (cnt_q + 8'd1 == ACK_TIMEOUT) begin
                    state_d = WR_DONE;
                    to_d    = 1'b1;
                end
            end
            WR_DONE: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0
              : (state_q == RX_WAIT_ACK || state_q == WR_WAIT) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            grant_q   <= 2'd0;
            last_q    <= 2'd3;
            wr_byte_q <= 8'h00;
            rx_data_q <= 8'h00;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wr_byte_q <= wr_byte_d;
            rx_data_q <= rx_data_d;
            to_q      <= to_d;
        end
    end

    // A timed-out write still passes through WR_DONE but must not report success
    assign EP_WR_DONE    = (state_q == WR_DONE && !to_q) ? onehot4(grant_q) : '0;
    assign EP_RX_VALID   = (state_q == RX_WAIT_ACK) ? onehot4(target) : '0;
    assign EP_RX_DATA    = rx_data_q;
    assign WRITE_EN      = state_q == WR_ISSUE || state_q == WR_WAIT;
    assign WRITE_BYTE    = wr_byte_q;
    assign RSB_INT_EN    = state_q == RX_RELEASE;
    assign ENDPOINT_BUSY = state_q != IDLE && state_q != RX_RELEASE;
    assign TIMEOUT_ERR   = to_q;

endmodule
